// File: rtl/dtree_feature_loader_if.sv
// Byte-stream input and result output handshakes of the decision-tree feature loader.
// The loader connects as slave; the producer/consumer side connects as master.
interface dtree_feature_loader_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         res_valid;
    logic         res_ready;
    logic         res_class;

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_class
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_class
    );
endinterface

// File: rtl/dtree_feature_loader.sv
// Assembles a 5-byte feature vector for the combinational decision tree, holds it for a
// settle window, samples the tree's class bit and hands it off over a valid/ready port.
module dtree_feature_loader #(
    parameter int unsigned W          = 8,
    parameter int unsigned SETTLE     = 2,
    parameter bit          CHECK_LAST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    dtree_feature_loader_if.slave bus,
    output logic [W-1:0]          X0,
    output logic [W-1:0]          X1,
    output logic [W-1:0]          X2,
    output logic [W-1:0]          X3,
    output logic [W-1:0]          X4,
    input  logic                  tree_out,
    output logic                  err_frame,
    output logic [15:0]           res_count
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_PRESENT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [W-1:0]  x_q [5];
    logic [W-1:0]  x_d [5];
    logic          cls_q, cls_d;
    logic          err_q, err_d;
    logic [15:0]   res_count_q, res_count_d;
    logic          frame_ok;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        cls_d       = cls_q;
        err_d       = 1'b0;
        res_count_d = res_count_q;
        frame_ok    = 1'b1;

        unique case (state_q)
            ST_LOAD: begin
                if (bus.in_valid) begin
                    // in_last must be set exactly on the fifth byte of a frame
                    frame_ok = !CHECK_LAST || (bus.in_last == (idx_q == 3'd4));
                    if (!frame_ok) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < 5; i++) begin
                            if (idx_q == 3'(i)) x_d[i] = bus.in_data;
                        end
                        if (idx_q == 3'd4) begin
                            idx_d   = '0;
                            cnt_d   = 4'(SETTLE);
                            state_d = ST_SETTLE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    cls_d   = tree_out;
                    state_d = ST_PRESENT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_PRESENT: begin
                if (bus.res_ready) begin
                    res_count_d = res_count_q + 16'd1;
                    state_d     = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            x_q         <= '{default: '0};
            cls_q       <= 1'b0;
            err_q       <= 1'b0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            cls_q       <= cls_d;
            err_q       <= err_d;
            res_count_q <= res_count_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.res_valid = (state_q == ST_PRESENT);
    assign bus.res_class = cls_q;
    assign X0            = x_q[0];
    assign X1            = x_q[1];
    assign X2            = x_q[2];
    assign X3            = x_q[3];
    assign X4            = x_q[4];
    assign err_frame     = err_q;
    assign res_count     = res_count_q;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Bench for dtree_feature_loader: a frame-level model checked every cycle against the
// SETTLE=2 instance, plus directed literal checks on it and on a SETTLE=0 instance.
module tb_dtree_feature_loader;

    localparam int unsigned SA = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dtree_feature_loader_if #(.W(8)) ia ();
    dtree_feature_loader_if #(.W(8)) ib ();

    logic [7:0]  xa0, xa1, xa2, xa3, xa4;
    logic [7:0]  xb0, xb1, xb2, xb3, xb4;
    logic        tree_a, tree_b, err_a, err_b;
    logic [15:0] cnt_a, cnt_b;

    // tree stub: class 1 when X0 >= 64
    assign tree_a = (xa0 >= 8'd64);
    assign tree_b = (xb0 >= 8'd64);

    dtree_feature_loader #(.W(8), .SETTLE(SA), .CHECK_LAST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave),
        .X0(xa0), .X1(xa1), .X2(xa2), .X3(xa3), .X4(xa4),
        .tree_out(tree_a), .err_frame(err_a), .res_count(cnt_a)
    );

    dtree_feature_loader #(.W(8), .SETTLE(0), .CHECK_LAST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave),
        .X0(xb0), .X1(xb1), .X2(xb2), .X3(xb3), .X4(xb4),
        .tree_out(tree_b), .err_frame(err_b), .res_count(cnt_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame-level model: bytes collected into a frame, a settle countdown, a pending result.
    logic [7:0]  m_x [5];
    int          m_n;
    int          m_settle;
    bit          m_pres;
    logic        m_cls;
    logic        m_err;
    logic [15:0] m_cnt;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_live   = 1'b1;
            m_n      = 0;
            m_settle = 0;
            m_pres   = 1'b0;
            m_cls    = 1'b0;
            m_err    = 1'b0;
            m_cnt    = 16'd0;
            for (int i = 0; i < 5; i++) m_x[i] = 8'd0;
        end else begin
            m_err = 1'b0;
            if (m_pres) begin
                if (ia.res_ready) begin
                    m_cnt  = m_cnt + 16'd1;
                    m_pres = 1'b0;
                end
            end else if (m_settle > 0) begin
                m_settle--;
                if (m_settle == 0) begin
                    m_pres = 1'b1;
                    m_cls  = (m_x[0] >= 8'd64);
                end
            end else if (ia.in_valid) begin
                if (ia.in_last != (m_n == 4)) begin
                    m_n   = 0;
                    m_err = 1'b1;
                end else begin
                    m_x[m_n] = ia.in_data;
                    if (m_n == 4) begin
                        m_n      = 0;
                        m_settle = SA + 1;
                    end else begin
                        m_n++;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_live) begin
            chk("in_ready", ia.in_ready, (!m_pres && m_settle == 0));
            chk("res_valid", ia.res_valid, m_pres);
            chk("res_class", ia.res_class, m_cls);
            chk("err_frame", err_a, m_err);
            chk("res_count", cnt_a, m_cnt);
            chk("X0", xa0, m_x[0]);
            chk("X1", xa1, m_x[1]);
            chk("X2", xa2, m_x[2]);
            chk("X3", xa3, m_x[3]);
            chk("X4", xa4, m_x[4]);
        end
    end

    // All stimulus tasks start and end just after a falling edge.
    task automatic send_a(input logic [7:0] d, input logic l);
        int n = 0;
        while (!ia.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ia.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        ia.in_valid = 1'b1;
        ia.in_data  = d;
        ia.in_last  = l;
        @(posedge clk);
        @(negedge clk);
        ia.in_valid = 1'b0;
        ia.in_last  = 1'b0;
    endtask

    task automatic frame_a(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4);
        send_a(b0, 1'b0);
        send_a(b1, 1'b0);
        send_a(b2, 1'b0);
        send_a(b3, 1'b0);
        send_a(b4, 1'b1);
    endtask

    // Edges after the X4 accept edge until res_valid is seen just after an edge.
    task automatic wait_res_a(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!ia.res_valid && edges < 100);
        if (!ia.res_valid) chk("res_valid_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic handoff_a();
        ia.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ia.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        ia.in_valid = 1'b0; ia.in_data = 8'd0; ia.in_last = 1'b0; ia.res_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = 8'd0; ib.in_last = 1'b0; ib.res_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("idle_in_ready", ia.in_ready, 1);
        chk("idle_res_valid", ia.res_valid, 0);
        chk("idle_x0", xa0, 0);
        chk("idle_count", cnt_a, 0);
        chk("idle_err", err_a, 0);

        // res_valid high right after edge SETTLE+1, i.e. seen by an edge sampler at edge SETTLE+2
        frame_a(8'h80, 8'h10, 8'h20, 8'h30, 8'h40);
        wait_res_a(e);
        chk("latency_s2", e, 3);
        chk("class_first", ia.res_class, 1);
        chk("x0_first", xa0, 8'h80);
        chk("x4_first", xa4, 8'h40);

        repeat (10) @(negedge clk);
        chk("stall_valid", ia.res_valid, 1);
        chk("stall_in_ready", ia.in_ready, 0);
        chk("stall_class", ia.res_class, 1);
        handoff_a();
        chk("count_one", cnt_a, 1);
        chk("ready_after_handoff", ia.in_ready, 1);
        chk("valid_after_handoff", ia.res_valid, 0);

        frame_a(8'h3F, 8'h10, 8'h20, 8'h30, 8'h40);
        wait_res_a(e);
        chk("class_low", ia.res_class, 0);
        handoff_a();

        // in_last on the third byte
        send_a(8'h01, 1'b0);
        send_a(8'h02, 1'b0);
        send_a(8'h03, 1'b1);
        chk("err_pulse_a", err_a, 1);
        chk("stale_x2", xa2, 8'h20);
        chk("new_x1", xa1, 8'h02);
        @(negedge clk);
        chk("err_one_cycle_a", err_a, 0);
        chk("err_no_result_a", ia.res_valid, 0);
        frame_a(8'hC0, 8'h11, 8'h22, 8'h33, 8'h44);
        wait_res_a(e);
        chk("class_after_err", ia.res_class, 1);
        chk("x2_after_err", xa2, 8'h22);
        handoff_a();

        // fifth byte without in_last
        send_a(8'h05, 1'b0);
        send_a(8'h06, 1'b0);
        send_a(8'h07, 1'b0);
        send_a(8'h08, 1'b0);
        send_a(8'h09, 1'b0);
        chk("err_pulse_b", err_a, 1);
        chk("stale_x4", xa4, 8'h44);
        @(negedge clk);
        chk("err_one_cycle_b", err_a, 0);
        frame_a(8'h41, 8'h01, 8'h02, 8'h03, 8'h04);
        wait_res_a(e);
        chk("class_0x41", ia.res_class, 1);
        handoff_a();
        chk("count_four", cnt_a, 4);

        // reset while settling
        frame_a(8'h50, 8'h01, 8'h02, 8'h03, 8'h04);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_settle_valid", ia.res_valid, 0);
        chk("rst_settle_ready", ia.in_ready, 1);
        chk("rst_settle_count", cnt_a, 0);
        repeat (5) @(negedge clk);
        chk("rst_settle_no_result", ia.res_valid, 0);

        // reset while presenting
        frame_a(8'h90, 8'h01, 8'h02, 8'h03, 8'h04);
        wait_res_a(e);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_present_valid", ia.res_valid, 0);
        chk("rst_present_ready", ia.in_ready, 1);
        chk("rst_present_x0", xa0, 0);

        // counter wrap
        force dut_a.res_count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_a.res_count_q;
        @(negedge clk);
        chk("preload_count", cnt_a, 16'hFFFF);
        frame_a(8'h80, 8'h01, 8'h02, 8'h03, 8'h04);
        wait_res_a(e);
        handoff_a();
        chk("count_wrap", cnt_a, 0);

        // SETTLE=0 instance
        for (int i = 0; i < 5; i++) begin
            ib.in_valid = 1'b1;
            ib.in_data  = 8'h70 + 8'(i);
            ib.in_last  = (i == 4);
            @(posedge clk);
            @(negedge clk);
        end
        ib.in_valid = 1'b0;
        ib.in_last  = 1'b0;
        e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
        end while (!ib.res_valid && e < 100);
        chk("latency_s0", e, 1);
        chk("class_s0", ib.res_class, 1);
        chk("x4_s0", xb4, 8'h74);
        chk("err_s0", err_b, 0);
        @(negedge clk);
        ib.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ib.res_ready = 1'b0;
        chk("count_s0", cnt_b, 1);
        chk("ready_s0", ib.in_ready, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
